// File: rtl/tank_pump_ctrl_pkg.sv
// tank_pkg: shared state encoding and defaults for the tank pump controller
package tank_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PUMP = 2'd1, REST = 2'd2, FAULT = 2'd3} state_t;
  localparam int DEF_LVL = 0;
endpackage

// File: rtl/tank_pump_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at MAX
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/tank_pump_ctrl.sv
// tank_pump_ctrl: hysteresis pump control with min on/off times and dry-run fault latch
module tank_pump_ctrl import tank_pkg::*; #(
  parameter int LW      = 8,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 16,
  parameter int DRY_CYC = 64,
  parameter int SW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [LW-1:0] lvl,
  input  logic [LW-1:0] low_th,
  input  logic [LW-1:0] high_th,
  input  logic          fault_clr,
  output logic          mot_on,
  output logic          fault,
  output logic          cfg_err,
  output logic [1:0]    state,
  output logic [SW-1:0] starts
);
  localparam int MX = (MIN_ON > MIN_OFF) ? ((MIN_ON > DRY_CYC) ? MIN_ON : DRY_CYC)
                                         : ((MIN_OFF > DRY_CYC) ? MIN_OFF : DRY_CYC);
  localparam int TW = (MX > 1) ? $clog2(MX) : 1;
  localparam logic [TW-1:0] ON_M  = TW'(MIN_ON - 1);
  localparam logic [TW-1:0] OFF_M = TW'(MIN_OFF - 1);
  localparam logic [TW-1:0] DRY_M = TW'(DRY_CYC - 1);
  state_t state_q, state_d;
  logic [LW-1:0] snap_q, snap_d;
  logic [TW-1:0] on_cnt, off_cnt, dry_cnt;
  logic hi, rise, start, dry_clr;
  assign cfg_err = low_th >= high_th;
  always_comb begin
    hi      = lvl >= high_th;
    rise    = lvl > snap_q;
    start   = state_q == IDLE && en && !cfg_err && lvl <= low_th;
    dry_clr = state_q != PUMP || hi || rise;
    snap_d  = (start || (state_q == PUMP && !hi && rise)) ? lvl : snap_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? PUMP : IDLE;
      PUMP:    state_d = (!en || cfg_err) ? REST
                       : hi ? ((on_cnt == ON_M) ? REST : PUMP)
                       : (!rise && dry_cnt == DRY_M) ? FAULT : PUMP;
      REST:    state_d = (off_cnt == OFF_M) ? IDLE : REST;
      default: state_d = fault_clr ? REST : FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      snap_q  <= LW'(DEF_LVL);
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
    end
  // timers clear whenever their owning state is not active, so they start at 0 on entry
  sat_counter #(.W(TW), .MAX(ON_M)) u_on (
    .clk(clk), .rst(rst), .clr(state_q != PUMP), .inc(1'b1), .q(on_cnt));
  sat_counter #(.W(TW), .MAX(OFF_M)) u_off (
    .clk(clk), .rst(rst), .clr(state_q != REST), .inc(1'b1), .q(off_cnt));
  sat_counter #(.W(TW), .MAX(DRY_M)) u_dry (
    .clk(clk), .rst(rst), .clr(dry_clr), .inc(1'b1), .q(dry_cnt));
  sat_counter #(.W(SW), .MAX({SW{1'b1}})) u_starts (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(start), .q(starts));
  assign mot_on = state_q == PUMP;
  assign fault  = state_q == FAULT;
  assign state  = state_q;
endmodule

// File: tb/tb_tank_pump_ctrl.sv
// tb_tank_pump_ctrl: vector table plus scoreboard queue for the tank pump controller
module tb_tank_pump_ctrl;
  import tank_pkg::*;
  typedef struct {
    logic       en;
    logic [7:0] lvl;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       fc;
    logic [1:0] st;
    int         starts;
    logic       cfg;
  } vec_t;
  logic clk, rst, en, fault_clr;
  logic [7:0] lvl, low_th, high_th;
  logic mot_on, fault, cfg_err, mot_on2, fault2, cfg2;
  logic [1:0] state, state2;
  logic [15:0] starts;
  logic [1:0] starts2;
  int checks = 0, failures = 0;
  vec_t vq[$];
  vec_t sb[$];
  tank_pump_ctrl #(.LW(8), .MIN_ON(4), .MIN_OFF(3), .DRY_CYC(8), .SW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .lvl(lvl), .low_th(low_th), .high_th(high_th),
    .fault_clr(fault_clr), .mot_on(mot_on), .fault(fault), .cfg_err(cfg_err),
    .state(state), .starts(starts));
  tank_pump_ctrl #(.LW(8), .MIN_ON(4), .MIN_OFF(3), .DRY_CYC(8), .SW(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .lvl(lvl), .low_th(low_th), .high_th(high_th),
    .fault_clr(fault_clr), .mot_on(mot_on2), .fault(fault2), .cfg_err(cfg2),
    .state(state2), .starts(starts2));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic e, input int l, input int lo, input int hi,
                              input logic fc, input logic [1:0] st, input int s, input logic c);
    vec_t v;
    v.en = e; v.lvl = 8'(l); v.lo = 8'(lo); v.hi = 8'(hi); v.fc = fc;
    v.st = st; v.starts = s; v.cfg = c;
    return v;
  endfunction
  task automatic add(input logic e, input int l, input int lo, input int hi,
                     input logic fc, input logic [1:0] st, input int s, input logic c);
    vq.push_back(mk(e, l, lo, hi, fc, st, s, c));
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    en = v.en; lvl = v.lvl; low_th = v.lo; high_th = v.hi; fault_clr = v.fc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state", int'(state), int'(e.st));
    chk("mot_on", int'(mot_on), int'(e.st == PUMP));
    chk("fault", int'(fault), int'(e.st == FAULT));
    chk("cfg_err", int'(cfg_err), int'(e.cfg));
    chk("starts", int'(starts), e.starts);
    chk("state_sw2", int'(state2), int'(e.st));
    chk("starts_sw2", int'(starts2), (e.starts > 3) ? 3 : e.starts);
    chk("outs_sw2", int'({mot_on2, fault2, cfg2}), int'({e.st == PUMP, e.st == FAULT, e.cfg}));
  endtask
  initial begin
    rst = 0; en = 0; lvl = 0; low_th = 20; high_th = 200; fault_clr = 0;
    // normal fill cycle with ramp to the high threshold
    add(1, 10, 20, 200, 0, PUMP, 1, 0);
    for (int l = 15; l <= 195; l += 5) add(1, l, 20, 200, 0, PUMP, 1, 0);
    add(1, 200, 20, 200, 0, REST, 1, 0);
    add(1, 205, 20, 200, 0, REST, 1, 0);
    add(1, 210, 20, 200, 0, REST, 1, 0);
    add(1, 210, 20, 200, 0, IDLE, 1, 0);
    add(1, 210, 20, 200, 0, IDLE, 1, 0);
    // minimum on-time
    add(1, 10, 20, 200, 0, PUMP, 2, 0);
    for (int i = 0; i < 3; i++) add(1, 250, 20, 200, 0, PUMP, 2, 0);
    for (int i = 0; i < 3; i++) add(1, 250, 20, 200, 0, REST, 2, 0);
    add(1, 250, 20, 200, 0, IDLE, 2, 0);
    // dry run, fault hold with en low, clear, fault_clr held outside FAULT
    add(1, 10, 20, 200, 0, PUMP, 3, 0);
    for (int i = 0; i < 7; i++) add(1, 10, 20, 200, 0, PUMP, 3, 0);
    add(1, 10, 20, 200, 0, FAULT, 3, 0);
    add(0, 10, 20, 200, 0, FAULT, 3, 0);
    add(0, 10, 20, 200, 0, FAULT, 3, 0);
    add(0, 10, 20, 200, 1, REST, 3, 0);
    add(1, 10, 20, 200, 1, REST, 3, 0);
    add(1, 10, 20, 200, 1, REST, 3, 0);
    add(1, 10, 20, 200, 1, IDLE, 3, 0);
    add(1, 10, 20, 200, 1, PUMP, 4, 0);
    // enable drop after one pump cycle
    for (int i = 0; i < 3; i++) add(0, 10, 20, 200, 0, REST, 4, 0);
    add(0, 10, 20, 200, 0, IDLE, 4, 0);
    add(0, 10, 20, 200, 0, IDLE, 4, 0);
    // config error blocks start and aborts pumping
    add(1, 0, 200, 20, 0, IDLE, 4, 1);
    add(1, 0, 200, 20, 0, IDLE, 4, 1);
    add(1, 0, 20, 200, 0, PUMP, 5, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 200, 20, 0, REST, 5, 1);
    add(1, 0, 200, 20, 0, IDLE, 5, 1);
    add(1, 0, 20, 200, 0, PUMP, 6, 0);
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_mot_on", int'(mot_on), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_starts", int'(starts), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    @(negedge clk);
    rst = 1;
    foreach (vq[i]) step(vq[i]);
    // asynchronous reset in the middle of pumping
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    chk("async_mot_on", int'(mot_on), 0);
    chk("async_state", int'(state), 0);
    chk("async_starts", int'(starts), 0);
    chk("async_starts_sw2", int'(starts2), 0);
    @(negedge clk);
    rst = 1;
    step(mk(1, 10, 20, 200, 0, PUMP, 1, 0));
    step(mk(1, 10, 20, 200, 0, PUMP, 1, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
